uart_rx_checker: RTL
====================

UART_RX_CHECKER -- requirements
Module: uart_rx_checker

Interface
REQ-001 Parameter CLK_FREQ, default 27000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 234 at defaults), HALF = CLKS_PER_BIT/2.
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 uart_rx_i  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 rx_data_o  output  8  last correctly framed byte; held until the next one.
REQ-007 rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.
REQ-008 frame_err_o  output  1  one-cycle pulse on a stop-bit error.
REQ-009 seq_err_o  output  1  one-cycle pulse when a byte breaks the 'A'/'C' alternation.
REQ-010 byte_count_o  output  16  count of valid bytes; wraps.
REQ-011 err_count_o  output  8  frame plus sequence errors; saturates at 255.
REQ-012 led_o  output  6  active-low status LEDs.

Function
REQ-013 uart_rx_i shall pass through a 2-flop synchronizer, with both flops reset to 1; all decoding uses the synchronized signal.
REQ-014 Receive FSM states: WAIT_IDLE, IDLE, START, DATA, STOP.
REQ-015 WAIT_IDLE shall move to IDLE on the first cycle the synchronized line is 1.
REQ-016 IDLE shall move to START on a synchronized 1->0 transition and clear the bit-timer.
REQ-017 START shall wait HALF clocks, then sample the line: 0 -> DATA with bit index 0 and timer cleared; 1 -> IDLE (glitch rejected, no output pulse, no count change).
REQ-018 DATA shall sample each bit CLKS_PER_BIT clocks after the previous sample.
REQ-019 DATA shall shift the 8 bits in LSB first, then move to STOP.
REQ-020 STOP shall sample the line CLKS_PER_BIT clocks after data bit 7.
REQ-021 A stop-bit sample of 1 shall load rx_data_o, pulse rx_valid_o on the next clock and go to IDLE; back-to-back frames shall be accepted with no idle gap beyond the half stop bit.
REQ-022 A stop-bit sample of 0 shall pulse frame_err_o on the next clock, leave rx_data_o unchanged and go to WAIT_IDLE.
REQ-023 rx_valid_o and frame_err_o shall never both be asserted in the same cycle.
REQ-024 Checker state: an expected byte and a synced flag, with synced = 0 after reset.
REQ-025 Checker, on rx_valid_o with synced = 0: a byte of 0x41 or 0x43 sets synced = 1 and sets expected to the other value, with no error; any other byte pulses seq_err_o.
REQ-026 Checker, on rx_valid_o with synced = 1: byte == expected toggles expected (0x41<->0x43).
REQ-027 Checker, on rx_valid_o with synced = 1 and a mismatch: pulse seq_err_o; if the byte is 0x41 or 0x43, resync expected to the other value; otherwise keep expected unchanged.
REQ-028 seq_err_o shall assert exactly one clock after the rx_valid_o of the offending byte.
REQ-029 byte_count_o shall increment by 1 on each rx_valid_o and wrap from 0xFFFF to 0x0000.
REQ-030 err_count_o shall increment on each frame_err_o or seq_err_o pulse and hold at 0xFF once reached; the two pulses cannot coincide, because a framing error produces no byte.
REQ-031 Sticky flags seq_sticky and frame_sticky shall set on the corresponding error pulse and clear only on reset.
REQ-032 led_o = ~{seq_sticky, frame_sticky, byte_count_o[3:0]}.

Reset
REQ-033 While rst_i = 1 at a clock edge, all outputs shall be forced to their reset values on that edge.
REQ-034 Output reset values: rx_data_o = 0x00; rx_valid_o, frame_err_o, seq_err_o = 0; byte_count_o = 0; err_count_o = 0; led_o = 6'b111111.
REQ-035 Reset shall also clear synced, both sticky flags, the bit-timer and the bit index, and set the FSM to WAIT_IDLE.
REQ-036 Reset mid-frame shall discard the partial byte; a line held low after reset shall not produce a start, because decoding waits in WAIT_IDLE until the line is high.

Verification
REQ-037 Frames 'A','C','A' at 115200 baud, 27 MHz -> three rx_valid_o pulses carrying 0x41, 0x43, 0x41; byte_count_o = 3; err_count_o = 0; seq_err_o never high; led_o = 6'b111100.
REQ-038 Frames 'A','A' -> seq_err_o pulses one clock after the second rx_valid_o; err_count_o = 1; led_o[5] = 0; a following 'C' raises no error.
REQ-039 Frame 0x41 with stop bit driven 0, then line high, then frame 'C' -> frame_err_o pulse, rx_data_o stays at its prior value, err_count_o = 1; 'C' is then received as 0x43 with no sequence error.
REQ-040 Low glitch of HALF-10 clocks on an idle line -> no pulses, FSM back in IDLE, all counters unchanged.
REQ-041 rst_i asserted during data bit 4, line held low through reset release -> no rx_valid_o; after the line returns high, the next frame 0x43 is received correctly with byte_count_o = 1.
REQ-042 300 consecutive 0x55 frames -> err_count_o saturates at 0xFF and holds; byte_count_o = 300.

Source files
------------

// File: rtl/uart_rx_checker.sv
// 8N1 UART receiver that checks incoming bytes alternate between 'A' and 'C',
// counting good bytes and errors and showing status on active-low LEDs.
module uart_rx_checker #(
  parameter int unsigned CLK_FREQ = 27000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uart_rx_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        frame_err_o,
  output logic        seq_err_o,
  output logic [15:0] byte_count_o,
  output logic [7:0]  err_count_o,
  output logic [5:0]  led_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned TW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [7:0]  CHAR_A       = 8'h41;
  localparam logic [7:0]  CHAR_C       = 8'h43;

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic [1:0]    prime_q;
  logic          rx_prev_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          seq_err_q, seq_err_d;
  logic          synced_q, synced_d;
  logic [7:0]    expected_q, expected_d;
  logic [15:0]   byte_count_q, byte_count_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          seq_sticky_q, seq_sticky_d;
  logic          frame_sticky_q, frame_sticky_d;

  logic          rx_s;
  logic          is_ac;
  logic [7:0]    other_char;

  assign rx_s       = sync_q[1];
  assign is_ac      = (rx_data_q == CHAR_A) || (rx_data_q == CHAR_C);
  assign other_char = (rx_data_q == CHAR_A) ? CHAR_C : CHAR_A;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      WAIT_IDLE: begin
        // The synchronizer resets to 1; ignore it until real line samples arrive.
        if (prime_q[1] && rx_s) state_d = IDLE;
      end
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == TW'(HALF - 1)) begin
          timer_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
          timer_d   = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
          timer_d = '0;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    synced_d       = synced_q;
    expected_d     = expected_q;
    seq_err_d      = 1'b0;
    byte_count_d   = byte_count_q;
    err_count_d    = err_count_q;
    seq_sticky_d   = seq_sticky_q | seq_err_q;
    frame_sticky_d = frame_sticky_q | frame_err_q;

    if (rx_valid_q) begin
      byte_count_d = byte_count_q + 16'd1;
      if (!synced_q) begin
        if (is_ac) begin
          synced_d   = 1'b1;
          expected_d = other_char;
        end else begin
          seq_err_d = 1'b1;
        end
      end else if (rx_data_q == expected_q) begin
        expected_d = other_char;
      end else begin
        seq_err_d = 1'b1;
        if (is_ac) expected_d = other_char;
      end
    end

    if ((frame_err_q || seq_err_q) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q         <= 2'b11;
      prime_q        <= 2'b00;
      rx_prev_q      <= 1'b1;
      state_q        <= WAIT_IDLE;
      timer_q        <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      seq_err_q      <= 1'b0;
      synced_q       <= 1'b0;
      expected_q     <= CHAR_A;
      byte_count_q   <= '0;
      err_count_q    <= '0;
      seq_sticky_q   <= 1'b0;
      frame_sticky_q <= 1'b0;
    end else begin
      sync_q         <= {sync_q[0], uart_rx_i};
      prime_q        <= {prime_q[0], 1'b1};
      rx_prev_q      <= rx_s;
      state_q        <= state_d;
      timer_q        <= timer_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_err_q    <= frame_err_d;
      seq_err_q      <= seq_err_d;
      synced_q       <= synced_d;
      expected_q     <= expected_d;
      byte_count_q   <= byte_count_d;
      err_count_q    <= err_count_d;
      seq_sticky_q   <= seq_sticky_d;
      frame_sticky_q <= frame_sticky_d;
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign frame_err_o  = frame_err_q;
  assign seq_err_o    = seq_err_q;
  assign byte_count_o = byte_count_q;
  assign err_count_o  = err_count_q;
  assign led_o        = ~{seq_sticky_q, frame_sticky_q, byte_count_q[3:0]};

endmodule
